mul12u_share_sched: RTL and testbench
=====================================

Name: mul12u_share_sched

Overview:
- Shares one truncation-based approximate 12x12 unsigned multiplier between N_REQ requesters.
- Round-robin arbitration with valid/ready handshakes on both request and response sides.
- Operand truncation level is a run-time input: keep top cfg_keep bits of each operand, zero the rest.
- Two-stage pipeline: operand register, then product register. Full backpressure; the pipeline holds one product per stage.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 12, operand width; product width is 2*WIDTH.
- ID_W, 2, response tag width; must satisfy 2**ID_W >= N_REQ.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operand valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high per cycle.
- req_a  in  N_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  operand B, same packing as req_a.
- cfg_keep  in  4  number of operand MSBs kept; sampled at accept.
- rsp_valid  out  1  product valid.
- rsp_ready  in  1  consumer accept.
- rsp_data  out  2*WIDTH  approximate product.
- rsp_id  out  ID_W  index of the requester that issued the product.
- busy  out  1  high if either pipeline stage is occupied.

Behaviour:
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
  - Stage-valid flags v1=v2=0; round-robin pointer=0.
- Stage advance rules:
  - adv2 = !v2 | rsp_ready.
  - adv1 = !v1 | adv2.
- Arbitration:
  - Combinational round-robin over req_valid, starting at the pointer.
  - The grant is the first valid index at or after the pointer, wrapping modulo N_REQ.
  - req_ready[g] = adv1 & req_valid[g]; all other req_ready bits are 0.
  - The pointer is updated only on accept, to (g+1) mod N_REQ.
- Accept (req_valid[g] & req_ready[g]):
  - Stage 1 captures masked A, masked B, id=g and sets v1.
  - Masking: k = min(cfg_keep,12); keep bits [11:12-k]; zero all lower bits.
  - k=0 gives zero operands; k=12 is exact.
  - A cfg_keep change affects only transactions accepted after the change.
- Stage-1 to stage-2 transfer when v1 & adv2: product = a1*b1, full 24-bit, no truncation of the result; stage 2 takes the id; v2 set.
- v1 is cleared when stage 1 drains without a new accept in the same cycle.
- v2 is cleared when rsp_valid & rsp_ready with no incoming stage-1 data.
- Outputs: rsp_valid=v2; rsp_data and rsp_id come from the stage-2 register and stay stable while rsp_valid & !rsp_ready.
- Latency: accept in cycle t gives rsp_valid in cycle t+2 when unstalled. Throughput is one product per cycle.
- Simultaneous events:
  - Accept, stage shift and response pop in the same cycle all occur; no bubble is inserted.
  - When both stages are full and rsp_ready=0, all req_ready are 0 and nothing is lost.
- Requester obligations: a requester holds req_a/req_b stable while valid and not ready. The block does not check this.
- Reset mid-operation: in-flight products are discarded, the pointer returns to 0 and no response is emitted for them.
- busy = v1 | v2.

Decomposition:
- Package mul12_approx_pkg:
  - Constants WIDTH=12 and KEEP_W=4.
  - Product typedef prod_t (24 bits).
  - Function trunc_mask(k) returning the 12-bit keep mask with clamp at 12.
- Sub-module rr_arb:
  - Parameter N.
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant and encoded index.
  - Stateless; the pointer register lives in the parent.

Test Plan:
- keep=12, requester 0 sends A=0xFFF, B=0xFFF, rsp_ready=1 → rsp_valid 2 cycles after accept; rsp_data=0xFFE001 (16769025); rsp_id=0.
- keep=3, A=0xFFF, B=0xFFF → operands 0xE00, 0xE00; rsp_data=0xC40000 (12845056). The same values with keep=15 clamp to exact → 0xFFE001. keep=0 → 0.
- All 4 requesters valid continuously with distinct operands (A=i+1, B=2, keep=12) → accept order 0,1,2,3,0,1; rsp_id sequence matches; rsp_data=2,4,6,8,...; one response per cycle.
- Backpressure:
  - Stimulus: 3 back-to-back requests, rsp_ready=0 for 5 cycles, then 1.
  - Required: after 2 accepts all req_ready=0 and rsp_data stays constant.
  - On release, 3 responses arrive in order with no loss or duplication.
- Reset pulse one cycle after an accept with rsp_ready=1 → no rsp_valid emitted; busy=0 the next cycle. A following request from requester 2 is granted with the pointer at 0.

Source files
------------

// File: rtl/mul12_approx_pkg.sv
// Shared types and helpers for the shared approximate 12x12 multiplier.
// The operand mask keeps the top k bits; k saturates at the operand width.
package mul12_approx_pkg;
  localparam int WIDTH  = 12;
  localparam int KEEP_W = 4;

  typedef logic [2*WIDTH-1:0] prod_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } opnd_t;

  function automatic logic [WIDTH-1:0] trunc_mask(input logic [KEEP_W-1:0] k);
    logic [WIDTH-1:0] ones;
    int kc;
    ones = '1;
    kc   = (int'(k) > WIDTH) ? WIDTH : int'(k);
    return ~(ones >> kc);
  endfunction
endpackage

// File: rtl/mul12u_share_sched_rr_arb.sv
// Stateless round-robin arbiter: first requester at or after ptr wins.
// The pointer register lives in the parent.
module rr_arb #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  always_comb begin
    logic found;
    int   j;
    found = 1'b0;
    j     = 0;
    idx   = '0;
    gnt   = '0;
    for (int off = 0; off < N; off++) begin
      j = (int'(ptr) + off) % N;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
    if (en && found) gnt = N'(1) << idx;
  end
endmodule

// File: rtl/mul12u_share_sched.sv
// One truncating 12x12 multiplier shared by N_REQ requesters through a
// round-robin arbiter and a two-stage (operand, product) backpressured pipeline.
module mul12u_share_sched
  import mul12_approx_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 12,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [3:0]             cfg_keep,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [2*WIDTH-1:0]     rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy
);
  logic             v1, v2, adv1, adv2, accept;
  logic [ID_W-1:0]  ptr, ptr_next, g, id1, id2;
  logic [N_REQ-1:0] gnt;
  logic [WIDTH-1:0] mask, sel_a, sel_b;
  opnd_t            s1;
  prod_t            prod;

  assign adv2 = !v2 || rsp_ready;
  assign adv1 = !v1 || adv2;

  // Grant is suppressed during reset so req_ready reads 0 there.
  rr_arb #(.N(N_REQ), .IW(ID_W)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .en  (adv1 && !rst),
    .gnt (gnt),
    .idx (g)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;
  assign mask      = trunc_mask(cfg_keep);
  assign sel_a     = req_a[g*WIDTH +: WIDTH] & mask;
  assign sel_b     = req_b[g*WIDTH +: WIDTH] & mask;
  assign ptr_next  = (int'(g) == N_REQ-1) ? '0 : g + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      ptr  <= '0;
      s1   <= '0;
      id1  <= '0;
      prod <= '0;
      id2  <= '0;
    end else begin
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          prod <= prod_t'(s1.a) * prod_t'(s1.b);
          id2  <= id1;
        end
      end
      if (adv1) begin
        v1 <= accept;
        if (accept) begin
          s1  <= '{a: sel_a, b: sel_b};
          id1 <= g;
          ptr <= ptr_next;
        end
      end
    end
  end

  assign rsp_valid = v2;
  assign rsp_data  = prod;
  assign rsp_id    = id2;
  assign busy      = v1 || v2;
endmodule

// File: tb/tb_mul12u_share_sched.sv
// Bench for mul12u_share_sched: directed scenarios plus random traffic
// checked against a queue-based model of the two-slot pipeline.
module tb_mul12u_share_sched;
  localparam int N = 4;
  localparam int W = 12;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic [3:0]     cfg_keep = 4'd12;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [2*W-1:0] rsp_data;
  logic [1:0]     rsp_id;
  logic           busy;

  always #5 clk = ~clk;

  mul12u_share_sched #(.N_REQ(N), .WIDTH(W), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .cfg_keep(cfg_keep), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  typedef struct { int data; int id; bit out; } item_t;
  item_t    mq[$];
  int       mptr = 0;
  logic [N-1:0] exp_ready;
  logic     exp_rv, exp_busy;
  int       exp_data, exp_id, exp_g;
  int       n_vec = 0, n_err = 0;
  int       cur_a[N], cur_b[N];

  function automatic int ref_prod(input int a, input int b, input int keep);
    int s;
    s = 12 - ((keep > 12) ? 12 : keep);
    return ((a >> s) << s) * ((b >> s) << s);
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = W'(cur_a[i]);
      req_b[i*W +: W] = W'(cur_b[i]);
    end
  endtask

  // Model: at most two in-flight items; an item reaches the output one edge
  // after it was accepted, if the output slot is free by then.
  task automatic model_eval();
    bit can;
    can   = (mq.size() < 2) || rsp_ready;
    exp_g = -1;
    for (int off = 0; off < N; off++) begin
      int j;
      j = (mptr + off) % N;
      if (exp_g < 0 && req_valid[j]) exp_g = j;
    end
    exp_ready = '0;
    if (can && !rst && exp_g >= 0) exp_ready[exp_g] = 1'b1;
    exp_rv   = (mq.size() > 0) && mq[0].out;
    exp_busy = mq.size() > 0;
    exp_data = exp_rv ? mq[0].data : 0;
    exp_id   = exp_rv ? mq[0].id : 0;
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    if (rst) begin
      mq.delete();
      mptr = 0;
    end else begin
      if (exp_rv && rsp_ready) void'(mq.pop_front());
      if (mq.size() == 1 && !mq[0].out) mq[0].out = 1'b1;
      if (exp_ready != '0) begin
        mq.push_back('{ref_prod(cur_a[exp_g], cur_b[exp_g], int'(cfg_keep)), exp_g, 1'b0});
        mptr = (exp_g + 1) % N;
      end
    end
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1; req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    tick(); tick();
    @(negedge clk);
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %0h want 0", rsp_valid); end
    n_vec++; if (rsp_data !== '0) begin n_err++; $display("FAIL reset_rsp_data got %0h want 0", rsp_data); end
    n_vec++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id got %0h want 0", rsp_id); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0h want 0", busy); end
    req_valid = 4'hF;
    #1;
    n_vec++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL reset_req_ready got %0h want 0", req_ready); end
    req_valid = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_trunc();
    int keeps[4] = '{12, 3, 15, 0};
    int exps[4]  = '{32'hFFE001, 32'hC40000, 32'hFFE001, 0};
    rsp_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      cur_a[0] = 12'hFFF; cur_b[0] = 12'hFFF; drive_ops();
      cfg_keep = 4'(keeps[t]); req_valid = 4'b0001;
      @(negedge clk);
      n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL trunc_grant k=%0d got %0h want 1", keeps[t], req_ready); end
      tick();
      req_valid = '0; cfg_keep = 4'd0;  // later keep change must not touch this product
      @(negedge clk);
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL trunc_early_valid k=%0d got %0h want 0", keeps[t], rsp_valid); end
      tick();
      @(negedge clk);
      n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL trunc_valid k=%0d got %0h want 1", keeps[t], rsp_valid); end
      n_vec++; if (rsp_data !== 24'(exps[t])) begin n_err++; $display("FAIL trunc_data k=%0d got %0h want %0h", keeps[t], rsp_data, exps[t]); end
      n_vec++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL trunc_id k=%0d got %0h want 0", keeps[t], rsp_id); end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] oh;
    pulse_reset();
    for (int i = 0; i < N; i++) begin cur_a[i] = i + 1; cur_b[i] = 2; end
    drive_ops();
    cfg_keep = 4'd12; rsp_ready = 1'b1; req_valid = 4'hF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      oh = 4'b0001 << (c % N);
      n_vec++; if (req_ready !== oh) begin n_err++; $display("FAIL rr_grant c=%0d got %0h want %0h", c, req_ready, oh); end
      if (c >= 2) begin
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rr_valid c=%0d got %0h want 1", c, rsp_valid); end
        n_vec++; if (rsp_id !== 2'((c - 2) % N)) begin n_err++; $display("FAIL rr_id c=%0d got %0h want %0h", c, rsp_id, (c - 2) % N); end
        n_vec++; if (rsp_data !== 24'(2 * ((c - 2) % N + 1))) begin n_err++; $display("FAIL rr_data c=%0d got %0h want %0h", c, rsp_data, 2 * ((c - 2) % N + 1)); end
      end else begin
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rr_fill c=%0d got %0h want 0", c, rsp_valid); end
      end
      tick();
    end
    req_valid = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_backpressure();
    int e[3];
    int got_id[$];
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      cur_a[i] = $urandom_range(1, 4095); cur_b[i] = $urandom_range(1, 4095);
      e[i] = cur_a[i] * cur_b[i];
    end
    drive_ops();
    cfg_keep = 4'd12; rsp_ready = 1'b0; req_valid = 4'b0111;
    for (int c = 0; c < 14; c++) begin
      rsp_ready = (c >= 5);
      @(negedge clk);
      model_eval();
      n_vec++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL bp_ready c=%0d got %0h want %0h", c, req_ready, exp_ready); end
      if (c >= 2 && c < 5) begin
        n_vec++; if (req_ready !== 4'h0) begin n_err++; $display("FAIL bp_stall_ready c=%0d got %0h want 0", c, req_ready); end
        n_vec++; if (rsp_data !== 24'(e[0]) || rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold c=%0d got %0h/%0h want %0h/1", c, rsp_data, rsp_valid, e[0]); end
      end
      if (rsp_valid && rsp_ready) begin
        got_id.push_back(int'(rsp_id));
        if (got_id.size() <= 3) begin
          n_vec++; if (rsp_data !== 24'(e[got_id.size() - 1])) begin n_err++; $display("FAIL bp_data n=%0d got %0h want %0h", got_id.size(), rsp_data, e[got_id.size() - 1]); end
        end
      end
      tick();
      req_valid = req_valid & ~exp_ready;
    end
    n_vec++; if (got_id.size() != 3) begin n_err++; $display("FAIL bp_count got %0d want 3", got_id.size()); end
    for (int i = 0; i < 3 && i < got_id.size(); i++) begin
      n_vec++; if (got_id[i] != i) begin n_err++; $display("FAIL bp_order n=%0d got %0d want %0d", i, got_id[i], i); end
    end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    rsp_ready = 1'b1; cfg_keep = 4'd12;
    cur_a[0] = 5; cur_b[0] = 7; cur_a[2] = 9; cur_b[2] = 3; drive_ops();
    req_valid = 4'b0001;
    tick();
    req_valid = '0; rst = 1'b1;
    tick();
    rst = 1'b0; req_valid = 4'b0101;
    @(negedge clk);
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid got %0h want 0", rsp_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %0h want 0", busy); end
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rmid_ptr got %0h want 1", req_ready); end
    tick();
    req_valid = 4'b0100;
    @(negedge clk);
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL rmid_grant2 got %0h want 4", req_ready); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rmid_ghost got %0h want 0", rsp_valid); end
    tick();
    req_valid = '0;
    @(negedge clk);
    n_vec++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 24'd35) begin n_err++; $display("FAIL rmid_rsp got v=%0h id=%0h d=%0h want 1/0/23", rsp_valid, rsp_id, rsp_data); end
    tick(); tick(); tick();
  endtask

  task automatic test_random();
    pulse_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom % 3 == 0)) begin
          cur_a[i] = $urandom_range(0, 4095); cur_b[i] = $urandom_range(0, 4095);
          req_valid[i] = 1'b1;
        end
      end
      drive_ops();
      cfg_keep  = 4'($urandom % 16);
      rsp_ready = ($urandom % 4) != 0;
      @(negedge clk);
      model_eval();
      n_vec++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready c=%0d got %0h want %0h", c, req_ready, exp_ready); end
      n_vec++; if (rsp_valid !== exp_rv) begin n_err++; $display("FAIL rnd_valid c=%0d got %0h want %0h", c, rsp_valid, exp_rv); end
      n_vec++; if (busy !== exp_busy) begin n_err++; $display("FAIL rnd_busy c=%0d got %0h want %0h", c, busy, exp_busy); end
      if (exp_rv) begin
        n_vec++; if (rsp_data !== 24'(exp_data) || rsp_id !== 2'(exp_id)) begin n_err++; $display("FAIL rnd_rsp c=%0d got %0h/%0h want %0h/%0h", c, rsp_data, rsp_id, exp_data, exp_id); end
      end
      tick();
      req_valid = req_valid & ~exp_ready;
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin cur_a[i] = 0; cur_b[i] = 0; end
    test_reset();
    test_trunc();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
